// File: rtl/serial_deserializer_pkg.sv
// Shared constants for the serial receive path: bit-order encodings, default word width
// and the deserializer state encoding.
package serial_deserializer_pkg;

  localparam int BIT_ORDER_MSB  = 1;
  localparam int BIT_ORDER_LSB  = 0;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial-in / word-out bus of the deserializer; master drives the bit stream and ready,
// slave returns the assembled word and status.
interface serial_deserializer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
);
  logic              i_s;
  logic              i_s_valid;
  logic              i_sync;
  logic              i_ready;
  logic              i_ovr_clr;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_busy;
  logic [CNT_W-1:0]  o_bit_cnt;
  logic              o_overrun;

  modport master (
    output i_s, i_s_valid, i_sync, i_ready, i_ovr_clr,
    input  o_data, o_valid, o_busy, o_bit_cnt, o_overrun
  );

  modport slave (
    input  i_s, i_s_valid, i_sync, i_ready, i_ovr_clr,
    output o_data, o_valid, o_busy, o_bit_cnt, o_overrun
  );
endinterface

// File: rtl/serial_deserializer_out_hold_reg.sv
// Single-entry valid/ready word holding register with sticky overrun; load-to-valid is 1 cycle.
// Under backpressure the held word is kept and a colliding load is dropped and flagged.
module serial_deserializer_out_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_vld_i,
  input  logic [DATA_W-1:0] load_dat_i,
  input  logic              ready_i,
  input  logic              ovr_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              ovr_set;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ovr_set = 1'b0;
    if (load_vld_i) begin
      // A load may replace the held word only if it leaves this cycle.
      if (!valid_q || ready_i) begin
        data_d  = load_dat_i;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (ovr_clr_i) ovr_d = 1'b0;
    if (ovr_set)   ovr_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: word valid 1 cycle after its last bit; output held until ready,
// a word completing while the previous one is still held is dropped and sets sticky overrun.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int   DATA_W    = DEFAULT_DATA_W,
  parameter int   MSB_FIRST = BIT_ORDER_MSB,
  localparam int  CNT_W     = $clog2(DATA_W)
) (
  input logic                 i_clk,
  input logic                 i_rst,
  serial_deserializer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  deser_state_t      state_q;
  logic [DATA_W-1:0] sr_q, sr_d, sr_base;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
  logic              complete;

  always_comb begin
    // A resync pulse restarts the word before any bit sampled on the same edge.
    sr_base  = bus.i_sync ? '0 : sr_q;
    cnt_base = bus.i_sync ? '0 : cnt_q;
    sr_d     = sr_base;
    cnt_d    = cnt_base;
    complete = 1'b0;
    if (bus.i_s_valid) begin
      if (MSB_FIRST != 0) sr_d = {sr_base[DATA_W-2:0], bus.i_s};
      else                sr_d = {bus.i_s, sr_base[DATA_W-1:1]};
      if (cnt_base == LAST_CNT) begin
        cnt_d    = '0;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      state_q <= (cnt_d == '0) ? ST_IDLE : ST_SHIFT;
    end
  end

  serial_deserializer_out_hold_reg #(
    .DATA_W (DATA_W)
  ) u_out_hold (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_vld_i (complete),
    .load_dat_i (sr_d),
    .ready_i    (bus.i_ready),
    .ovr_clr_i  (bus.i_ovr_clr),
    .data_o     (bus.o_data),
    .valid_o    (bus.o_valid),
    .overrun_o  (bus.o_overrun)
  );

  assign bus.o_bit_cnt = cnt_q;
  assign bus.o_busy    = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_serial_deserializer;

  logic clk = 1'b0;
  logic rst, s, s_vld, sync, rdy, ovr_clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_deserializer_if #(.DATA_W(8)) ifa ();
  serial_deserializer_if #(.DATA_W(8)) ifb ();

  assign ifa.i_s = s;       assign ifb.i_s = s;
  assign ifa.i_s_valid = s_vld; assign ifb.i_s_valid = s_vld;
  assign ifa.i_sync = sync; assign ifb.i_sync = sync;
  assign ifa.i_ready = rdy; assign ifb.i_ready = rdy;
  assign ifa.i_ovr_clr = ovr_clr; assign ifb.i_ovr_clr = ovr_clr;

  serial_deserializer #(.DATA_W(8), .MSB_FIRST(1)) dut_msb (.i_clk(clk), .i_rst(rst), .bus(ifa));
  serial_deserializer #(.DATA_W(8), .MSB_FIRST(0)) dut_lsb (.i_clk(clk), .i_rst(rst), .bus(ifb));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b);
    s = b;
    s_vld = 1'b1;
    step();
  endtask

  logic [7:0] v;

  initial begin
    rst = 1'b1; s = 1'b0; s_vld = 1'b0; sync = 1'b0; rdy = 1'b0; ovr_clr = 1'b0;
    step(); step();
    chk("rst_data", 32'(ifa.o_data), 32'h0);
    chk("rst_valid", 32'(ifa.o_valid), 32'h0);
    chk("rst_ovr", 32'(ifa.o_overrun), 32'h0);
    chk("rst_cnt", 32'(ifa.o_bit_cnt), 32'h0);
    chk("rst_busy", 32'(ifa.o_busy), 32'h0);
    rst = 1'b0;
    rdy = 1'b1;

    // MSB-first basic
    v = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      send(v[i]);
      if (i > 0) begin
        chk("basic_busy", 32'(ifa.o_busy), 32'h1);
        chk("basic_nvalid", 32'(ifa.o_valid), 32'h0);
        chk("basic_cnt", 32'(ifa.o_bit_cnt), 32'(8 - i));
      end
    end
    chk("basic_valid", 32'(ifa.o_valid), 32'h1);
    chk("basic_data", 32'(ifa.o_data), 32'hA5);
    chk("basic_idle", 32'(ifa.o_busy), 32'h0);
    s_vld = 1'b0;
    step();
    chk("basic_pulse1", 32'(ifa.o_valid), 32'h0);

    // Gapped input
    v = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      send(v[i]);
      s_vld = 1'b0;
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          step();
          chk("gap_cnt_hold", 32'(ifa.o_bit_cnt), 32'(8 - i));
        end
      end else begin
        chk("gap_valid", 32'(ifa.o_valid), 32'h1);
        chk("gap_data", 32'(ifa.o_data), 32'h3C);
      end
    end
    step();
    chk("gap_taken", 32'(ifa.o_valid), 32'h0);

    // Backpressure and overrun
    rdy = 1'b0;
    v = 8'h11;
    for (int i = 7; i >= 0; i--) send(v[i]);
    chk("bp_valid1", 32'(ifa.o_valid), 32'h1);
    chk("bp_data1", 32'(ifa.o_data), 32'h11);
    chk("bp_novr", 32'(ifa.o_overrun), 32'h0);
    v = 8'h22;
    for (int i = 7; i >= 0; i--) send(v[i]);
    s_vld = 1'b0;
    chk("bp_data_kept", 32'(ifa.o_data), 32'h11);
    chk("bp_ovr_set", 32'(ifa.o_overrun), 32'h1);
    chk("bp_valid_kept", 32'(ifa.o_valid), 32'h1);
    rdy = 1'b1;
    step();
    chk("bp_accept", 32'(ifa.o_valid), 32'h0);
    step();
    chk("bp_ovr_sticky", 32'(ifa.o_overrun), 32'h1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("bp_ovr_clr", 32'(ifa.o_overrun), 32'h0);

    // Full throughput: transfer of word 1 coincides with completion of word 2
    v = 8'h0F;
    for (int i = 7; i >= 0; i--) send(v[i]);
    chk("ft_valid1", 32'(ifa.o_valid), 32'h1);
    chk("ft_data1", 32'(ifa.o_data), 32'h0F);
    rdy = 1'b0;
    v = 8'hF0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) rdy = 1'b1;
      send(v[i]);
      if (i > 0) chk("ft_hold", 32'(ifa.o_valid), 32'h1);
    end
    s_vld = 1'b0;
    chk("ft_valid2", 32'(ifa.o_valid), 32'h1);
    chk("ft_data2", 32'(ifa.o_data), 32'hF0);
    chk("ft_no_ovr", 32'(ifa.o_overrun), 32'h0);
    step();
    chk("ft_drain", 32'(ifa.o_valid), 32'h0);

    // Resync mid-word
    send(1'b1); send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    chk("rs_junk_cnt", 32'(ifa.o_bit_cnt), 32'h5);
    v = 8'h81;
    sync = 1'b1;
    send(v[7]);
    sync = 1'b0;
    chk("rs_cnt1", 32'(ifa.o_bit_cnt), 32'h1);
    for (int i = 6; i >= 0; i--) begin
      send(v[i]);
      if (i > 0) chk("rs_no_spurious", 32'(ifa.o_valid), 32'h0);
    end
    s_vld = 1'b0;
    chk("rs_valid", 32'(ifa.o_valid), 32'h1);
    chk("rs_data", 32'(ifa.o_data), 32'h81);
    step();

    // Reset mid-word
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    s_vld = 1'b0;
    chk("mr_cnt4", 32'(ifa.o_bit_cnt), 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_cnt", 32'(ifa.o_bit_cnt), 32'h0);
    chk("mr_busy", 32'(ifa.o_busy), 32'h0);
    chk("mr_data", 32'(ifa.o_data), 32'h0);
    chk("mr_valid", 32'(ifa.o_valid), 32'h0);
    chk("mr_ovr", 32'(ifa.o_overrun), 32'h0);

    // LSB-first instance against MSB-first on identical streams
    v = 8'hA5;
    for (int i = 7; i >= 0; i--) send(v[i]);
    s_vld = 1'b0;
    chk("lsb_a5_valid", 32'(ifb.o_valid), 32'h1);
    chk("lsb_a5_data", 32'(ifb.o_data), 32'hA5);
    step();
    v = 8'hD0;
    for (int i = 7; i >= 0; i--) send(v[i]);
    s_vld = 1'b0;
    chk("msb_d0_data", 32'(ifa.o_data), 32'hD0);
    chk("lsb_0b_data", 32'(ifb.o_data), 32'h0B);
    chk("lsb_0b_valid", 32'(ifb.o_valid), 32'h1);
    step();
    chk("lsb_drain", 32'(ifb.o_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
